rv32a_amo_unit: RTL and testbench
=================================

Name: rv32a_amo_unit

Overview:
Multi-cycle atomic-memory engine for the RV32IA core. It executes LR.W, SC.W and the nine AMO*.W operations as a read-modify-write sequence on a handshaked word memory port. It holds one load-reservation and invalidates it when another agent stores to the reserved granule. The core decodes an opcode 0101111 / func3 010 instruction, issues it here, and stalls until resp_valid.

Parameters:
ADDR_W, 32, memory address width in bits.
RESV_LOG2, 2, log2 of the reservation granule in bytes; legal range 2..12.
SNOOP_EN, 1, 1 = snooped stores clear the reservation; 0 = snoop port ignored.

Ports:
clk  in  1  clock
clr  in  1  reset, synchronous, active-high
req_valid  in  1  start an atomic op; sampled only when req_ready=1
req_ready  out  1  high only in IDLE
req_funct5  in  5  inst[31:27]
req_addr  in  ADDR_W  rs1 value
req_data  in  32  rs2 value
resp_valid  out  1  one-cycle pulse: result ready
resp_data  out  32  value written to rd
resp_err  out  1  with resp_valid: misaligned address or unsupported funct5
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  word address, bits [1:0] always 0
mem_wdata  out  32  store data
mem_rdata  in  32  load data, valid when mem_ack=1 on a read
mem_ack  in  1  request accepted/completed this cycle
snoop_valid  in  1  another agent stores this cycle
snoop_addr  in  ADDR_W  address of that store
resv_valid  out  1  reservation currently held

Behaviour:
- Reset (clr=1 at a clock edge), including mid-operation: state=IDLE, mem_req=0, mem_we=0, resp_valid=0, resp_err=0, resp_data=0, resv_valid=0. Any in-flight memory transaction is abandoned.
- States: IDLE, RD, WR, DONE.
- IDLE: req_ready=1. When req_valid=1, latch funct5, addr and data.
  - If addr[1:0]≠0 or funct5 is not in {00010 LR, 00011 SC, 00001 SWAP, 00000 ADD, 00100 XOR, 01100 AND, 01000 OR, 10000 MIN, 10100 MAX, 11000 MINU, 11100 MAXU}: go to DONE with resp_err=1 and resp_data=0. No memory access; the reservation is unchanged.
  - SC with resv_valid=1 and addr[ADDR_W-1:RESV_LOG2] equal to the reservation tag: go to WR; the result is 0.
  - SC otherwise: go to DONE with result 1 and no memory access.
  - Any SC clears resv_valid on this transition.
  - LR and AMO: go to RD.
- RD: mem_req=1, mem_we=0, mem_addr=addr.
  - Request signals are held stable until the edge where mem_ack=1; mem_rdata is captured as old on that edge.
  - LR then goes to DONE: result=old, reservation set to this granule. If a matching snoop occurs during RD or in the ack cycle, the reservation is not set.
  - AMO then goes to WR.
- WR: mem_req=1, mem_we=1, mem_wdata=new or, for SC, req_data. Held until mem_ack, then go to DONE. AMO result=old.
- new, computed on 32 bits with wrap-around:
  - SWAP: data.
  - ADD: old+data, carry discarded.
  - XOR, AND, OR: bitwise with data.
  - MIN, MAX: signed compare.
  - MINU, MAXU: unsigned compare.
  - On equal values MIN/MAX return old.
- DONE: resp_valid=1 for exactly one cycle with resp_data and resp_err, then IDLE. A request is not accepted in DONE. Minimum latency with same-cycle acks:
  - AMO: accept edge, then RD, WR, DONE → resp_valid 3 cycles after acceptance.
  - LR: 2 cycles.
  - Failing SC and error cases: 1 cycle.
- mem_req is 0 in IDLE and DONE. It is deasserted for at least the DONE cycle between transactions.
- Snoop (SNOOP_EN=1): snoop_valid with snoop_addr[ADDR_W-1:RESV_LOG2] equal to the tag clears resv_valid on that edge.
  - A snoop in the same IDLE cycle that accepts an SC clears first, so that SC fails.
  - A snoop during an SC in WR does not cancel the store.
- This unit's own AMO writes do not clear the reservation. Software ordering applies.
- aq/rl bits are ignored; the unit is fully serialising.

Test Plan:
- AMOADD: [0x100]=0x7FFFFFFF, data=1, mem_ack tied 1 → resp_valid 3 cycles after accept, resp_data=0x7FFFFFFF; write of 0x80000000 to 0x100 observed.
- LR/SC pair: LR 0x200 (mem=0xAA) → resp_data=0xAA, resv_valid=1; SC 0x204 data=5 → write 5 to 0x204, resp_data=0, resv_valid=0. Second SC → resp_data=1, no mem_req.
- Snoop: LR 0x300, then snoop_valid with snoop_addr=0x302 → resv_valid=0; SC 0x300 → resp_data=1, no write. Repeat with snoop_addr=0x310 → SC succeeds. Repeat with SNOOP_EN=0 → SC succeeds.
- AMOMIN vs AMOMINU: old=0xFFFFFFFF, data=1 → MIN writes 0xFFFFFFFF; MINU writes 1; both return 0xFFFFFFFF.
- Stalled memory and misalignment: mem_ack low for 4 cycles in RD → mem_req/mem_addr/mem_we stable throughout, AMO latency=7. Request at 0x102 → resp_err=1, resp_data=0, no mem_req.
- Reset mid-WR: assert clr while mem_req=1 → next cycle mem_req=0, req_ready=1, resv_valid=0, no resp_valid.

Source files
------------

// File: rtl/rv32a_amo_if.sv
// Request/response and word-memory handshake bundle for the RV32A atomic unit.
interface rv32a_amo_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_funct5;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_funct5, req_addr, req_data, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_data, resp_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_funct5, req_addr, req_data, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_data, resp_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv32a_amo_unit.sv
// RV32A atomic engine: LR.W / SC.W / AMO*.W as a read-modify-write sequence
// on a handshaked word port, with a single snoop-invalidated reservation.
module rv32a_amo_unit #(
  parameter int ADDR_W    = 32,
  parameter int RESV_LOG2 = 2,
  parameter bit SNOOP_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  rv32a_amo_if.slave        bus,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              resv_valid
);
  localparam int TAG_W = ADDR_W - RESV_LOG2;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state, state_next;
  logic [4:0]          op_f5;
  logic [ADDR_W-3:0]   op_word;
  logic [31:0]         op_data;
  logic [31:0]         result;
  logic                err;
  logic [TAG_W-1:0]    resv_tag;
  logic                lr_kill;
  logic [31:0]         new_val;
  logic [TAG_W-1:0]    req_tag, op_tag, snoop_tag;
  logic                req_err, req_sc, sc_ok;
  logic                snoop_resv_hit, snoop_op_hit;
  logic                snoop_unused;

  function automatic logic f5_legal(input logic [4:0] f);
    case (f)
      F_LR, F_SC, F_SWAP, F_ADD, F_XOR, F_AND, F_OR,
      F_MIN, F_MAX, F_MINU, F_MAXU: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  assign req_tag      = bus.req_addr[ADDR_W-1:RESV_LOG2];
  assign op_tag       = op_word[ADDR_W-3:RESV_LOG2-2];
  assign snoop_tag    = snoop_addr[ADDR_W-1:RESV_LOG2];
  assign snoop_unused = ^snoop_addr[RESV_LOG2-1:0];

  assign req_err = (bus.req_addr[1:0] != 2'b00) || !f5_legal(bus.req_funct5);
  assign req_sc  = (bus.req_funct5 == F_SC);
  assign snoop_resv_hit = SNOOP_EN && snoop_valid && resv_valid && (snoop_tag == resv_tag);
  assign snoop_op_hit   = SNOOP_EN && snoop_valid && (snoop_tag == op_tag);
  // A snoop on the accepting edge wins over the SC's reservation check.
  assign sc_ok = resv_valid && !snoop_resv_hit && (req_tag == resv_tag);

  // result holds the loaded old value while an AMO is in WR
  always_comb begin
    new_val = op_data;
    case (op_f5)
      F_ADD:  new_val = result + op_data;
      F_XOR:  new_val = result ^ op_data;
      F_AND:  new_val = result & op_data;
      F_OR:   new_val = result | op_data;
      F_MIN:  new_val = ($signed(op_data) < $signed(result)) ? op_data : result;
      F_MAX:  new_val = ($signed(op_data) > $signed(result)) ? op_data : result;
      F_MINU: new_val = (op_data < result) ? op_data : result;
      F_MAXU: new_val = (op_data > result) ? op_data : result;
      default: new_val = op_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.req_valid) begin
        if (req_err)     state_next = DONE;
        else if (req_sc) state_next = sc_ok ? WR : DONE;
        else             state_next = RD;
      end
      RD:   if (bus.mem_ack) state_next = (op_f5 == F_LR) ? DONE : WR;
      WR:   if (bus.mem_ack) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    bus.resp_err   = 1'b0;
    bus.mem_addr   = {op_word, 2'b00};
    bus.mem_wdata  = (op_f5 == F_SC) ? op_data : new_val;
    case (state)
      IDLE: bus.req_ready = 1'b1;
      RD:   bus.mem_req = 1'b1;
      WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = result;
        bus.resp_err   = err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      op_f5      <= '0;
      op_word    <= '0;
      op_data    <= '0;
      result     <= '0;
      err        <= 1'b0;
      resv_valid <= 1'b0;
      resv_tag   <= '0;
      lr_kill    <= 1'b0;
    end else begin
      if (snoop_resv_hit) resv_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          op_f5   <= bus.req_funct5;
          op_word <= bus.req_addr[ADDR_W-1:2];
          op_data <= bus.req_data;
          err     <= req_err;
          result  <= '0;
          lr_kill <= 1'b0;
          if (!req_err && req_sc) begin
            resv_valid <= 1'b0;
            result     <= {31'd0, !sc_ok};
          end
        end
        RD: begin
          if (snoop_op_hit) lr_kill <= 1'b1;
          if (bus.mem_ack) begin
            result <= bus.mem_rdata;
            // LR loses its reservation if its granule was stored to while reading.
            if (op_f5 == F_LR) begin
              resv_tag   <= op_tag;
              resv_valid <= !(lr_kill || snoop_op_hit);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32a_amo_unit.sv
// Self-checking bench for rv32a_amo_unit: vector table plus hand-written
// reservation, snoop, stall and reset sequences against a scoreboard.
module tb_rv32a_amo_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, sel, req_valid, snoop_valid;
  logic [4:0]  f5;
  logic [31:0] addr, data, snoop_addr;
  logic        resv0, resv1;
  logic        pre_we;
  logic [31:0] pre_addr, pre_data;
  int          rd_stall, wr_stall, stall_cnt;
  int          checks = 0, failures = 0;
  logic [31:0] mem [0:1023];

  rv32a_amo_if #(.ADDR_W(32)) b0 ();
  rv32a_amo_if #(.ADDR_W(32)) b1 ();

  rv32a_amo_unit #(.ADDR_W(32), .RESV_LOG2(3), .SNOOP_EN(1'b1)) dut0 (
    .clk(clk), .clr(clr), .bus(b0), .snoop_valid(snoop_valid),
    .snoop_addr(snoop_addr), .resv_valid(resv0));
  rv32a_amo_unit #(.ADDR_W(32), .RESV_LOG2(3), .SNOOP_EN(1'b0)) dut1 (
    .clk(clk), .clr(clr), .bus(b1), .snoop_valid(snoop_valid),
    .snoop_addr(snoop_addr), .resv_valid(resv1));

  assign b0.req_valid = req_valid & ~sel;
  assign b1.req_valid = req_valid & sel;
  assign b0.req_funct5 = f5;
  assign b1.req_funct5 = f5;
  assign b0.req_addr = addr;
  assign b1.req_addr = addr;
  assign b0.req_data = data;
  assign b1.req_data = data;
  assign b0.mem_rdata = mem[b0.mem_addr[11:2]];
  assign b1.mem_rdata = mem[b1.mem_addr[11:2]];

  logic        c_req, c_we, c_ack, c_ready, c_resp_valid, c_resp_err, c_resv;
  logic [31:0] c_addr, c_wdata, c_resp_data;
  assign c_req        = sel ? b1.mem_req    : b0.mem_req;
  assign c_we         = sel ? b1.mem_we     : b0.mem_we;
  assign c_addr       = sel ? b1.mem_addr   : b0.mem_addr;
  assign c_wdata      = sel ? b1.mem_wdata  : b0.mem_wdata;
  assign c_ready      = sel ? b1.req_ready  : b0.req_ready;
  assign c_resp_valid = sel ? b1.resp_valid : b0.resp_valid;
  assign c_resp_data  = sel ? b1.resp_data  : b0.resp_data;
  assign c_resp_err   = sel ? b1.resp_err   : b0.resp_err;
  assign c_resv       = sel ? resv1 : resv0;
  assign c_ack = c_req && (c_we ? (stall_cnt >= wr_stall) : (stall_cnt >= rd_stall));
  assign b0.mem_ack = c_ack && !sel;
  assign b1.mem_ack = c_ack && sel;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr[11:2]] <= pre_data;
    else if (c_req && c_we && c_ack) mem[c_addr[11:2]] <= c_wdata;
    if (c_req && !c_ack) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
  end

  typedef struct packed { logic err; logic [31:0] data; } resp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  resp_t sbq[$];
  wr_t   wq[$];

  typedef struct {
    logic [4:0]  f5;
    logic [31:0] addr, data, init, exp_d;
    logic        exp_e, exp_w;
    logic [31:0] exp_wd;
    int          lat, nreq;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] d,
                       input logic sv, input logic [31:0] sa);
    @(negedge clk);
    chk("req_ready", {31'd0, c_ready}, 32'd1);
    req_valid = 1'b1; f5 = f; addr = a; data = d;
    snoop_valid = sv; snoop_addr = sa;
    @(posedge clk);
    #1 req_valid = 1'b0; snoop_valid = 1'b0;
  endtask

  task automatic snoop_pulse(input logic [31:0] a);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_addr = a;
    @(posedge clk);
    #1 snoop_valid = 1'b0;
  endtask

  task automatic wait_resp(input string nm, output int lat, output int nreq, output logic unstable);
    logic done, prev_hold, pw;
    logic [31:0] pa, pwd;
    resp_t r;
    wr_t w;
    lat = 0; nreq = 0; unstable = 1'b0; done = 1'b0; prev_hold = 1'b0;
    pw = 1'b0; pa = '0; pwd = '0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (prev_hold && (c_req !== 1'b1 || c_we !== pw || c_addr !== pa || c_wdata !== pwd))
        unstable = 1'b1;
      prev_hold = c_req && !c_ack;
      pw = c_we; pa = c_addr; pwd = c_wdata;
      if (c_req) nreq++;
      if (c_req && c_we && c_ack) begin
        if (wq.size() == 0) chk({nm, "_unexpected_write"}, c_addr, 32'hxxxx_xxxx);
        else begin
          w = wq.pop_front();
          chk({nm, "_wr_addr"}, c_addr, w.addr);
          chk({nm, "_wr_data"}, c_wdata, w.data);
        end
      end
      if (c_resp_valid) begin
        done = 1'b1;
        if (sbq.size() == 0) chk({nm, "_unexpected_resp"}, c_resp_data, 32'hxxxx_xxxx);
        else begin
          r = sbq.pop_front();
          chk({nm, "_resp_data"}, c_resp_data, r.data);
          chk({nm, "_resp_err"}, {31'd0, c_resp_err}, {31'd0, r.err});
        end
      end
    end
    if (!done) chk({nm, "_resp_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic op(input string nm, input logic [4:0] f, input logic [31:0] a,
                    input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                    input logic exp_w, input logic [31:0] exp_wd, input int exp_lat,
                    input int exp_nreq, input logic sv, input logic [31:0] sa);
    int lat, nreq;
    logic unstable;
    sbq.push_back('{err: exp_e, data: exp_d});
    if (exp_w) wq.push_back('{addr: {a[31:2], 2'b00}, data: exp_wd});
    issue(f, a, d, sv, sa);
    wait_resp(nm, lat, nreq, unstable);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_mem_req_cycles"}, nreq, exp_nreq);
    chk({nm, "_mem_hold"}, {31'd0, unstable}, 32'd0);
  endtask

  localparam logic [4:0] ADD = 5'b00000, SWAP = 5'b00001, LR = 5'b00010, SC = 5'b00011;
  localparam logic [4:0] XOR = 5'b00100, OR = 5'b01000, AND = 5'b01100;
  localparam logic [4:0] MIN = 5'b10000, MAX = 5'b10100, MINU = 5'b11000, MAXU = 5'b11100;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    vecs[0]  = '{ADD,     32'h100, 32'h1,        32'h7fffffff, 32'h7fffffff, 1'b0, 1'b1, 32'h80000000, 3, 2};
    vecs[1]  = '{ADD,     32'h104, 32'h2,        32'hffffffff, 32'hffffffff, 1'b0, 1'b1, 32'h00000001, 3, 2};
    vecs[2]  = '{SWAP,    32'h108, 32'h0000abcd, 32'h00001234, 32'h00001234, 1'b0, 1'b1, 32'h0000abcd, 3, 2};
    vecs[3]  = '{XOR,     32'h10c, 32'hff00ff00, 32'hf0f0f0f0, 32'hf0f0f0f0, 1'b0, 1'b1, 32'h0ff00ff0, 3, 2};
    vecs[4]  = '{AND,     32'h110, 32'hff00ff00, 32'hf0f0f0f0, 32'hf0f0f0f0, 1'b0, 1'b1, 32'hf000f000, 3, 2};
    vecs[5]  = '{OR,      32'h114, 32'hff00ff00, 32'hf0f0f0f0, 32'hf0f0f0f0, 1'b0, 1'b1, 32'hfff0fff0, 3, 2};
    vecs[6]  = '{MIN,     32'h118, 32'h1,        32'hffffffff, 32'hffffffff, 1'b0, 1'b1, 32'hffffffff, 3, 2};
    vecs[7]  = '{MINU,    32'h11c, 32'h1,        32'hffffffff, 32'hffffffff, 1'b0, 1'b1, 32'h00000001, 3, 2};
    vecs[8]  = '{MAX,     32'h120, 32'h1,        32'hffffffff, 32'hffffffff, 1'b0, 1'b1, 32'h00000001, 3, 2};
    vecs[9]  = '{MAXU,    32'h124, 32'h1,        32'hffffffff, 32'hffffffff, 1'b0, 1'b1, 32'hffffffff, 3, 2};
    vecs[10] = '{MIN,     32'h128, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 3, 2};
    vecs[11] = '{MAX,     32'h12c, 32'h80000000, 32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000005, 3, 2};
    vecs[12] = '{ADD,     32'h102, 32'h1,        32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h0,        1, 0};
    vecs[13] = '{5'b00101, 32'h130, 32'h1,       32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h0,        1, 0};
    vecs[14] = '{SC,      32'h134, 32'h1,        32'h00000000, 32'h00000001, 1'b0, 1'b0, 32'h0,        1, 0};

    clr = 1'b1; sel = 1'b0; req_valid = 1'b0; snoop_valid = 1'b0;
    f5 = '0; addr = '0; data = '0; snoop_addr = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; rd_stall = 0; wr_stall = 0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, b0.req_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, b0.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, b0.mem_we}, 32'd0);
    chk("rst_resp_valid", {31'd0, b0.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, b0.resp_err}, 32'd0);
    chk("rst_resp_data", b0.resp_data, 32'd0);
    chk("rst_resv0", {31'd0, resv0}, 32'd0);
    chk("rst_resv1", {31'd0, resv1}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      preload(vecs[i].addr, vecs[i].init);
      op($sformatf("vec%0d", i), vecs[i].f5, vecs[i].addr, vecs[i].data, vecs[i].exp_d,
         vecs[i].exp_e, vecs[i].exp_w, vecs[i].exp_wd, vecs[i].lat, vecs[i].nreq, 1'b0, 32'h0);
    end

    preload(32'h200, 32'haa);
    op("lr200", LR, 32'h200, 32'h0, 32'haa, 1'b0, 1'b0, 32'h0, 2, 1, 1'b0, 32'h0);
    chk("lr200_resv", {31'd0, c_resv}, 32'd1);
    op("sc204", SC, 32'h204, 32'h5, 32'h0, 1'b0, 1'b1, 32'h5, 2, 1, 1'b0, 32'h0);
    chk("sc204_resv", {31'd0, c_resv}, 32'd0);
    op("sc204_again", SC, 32'h204, 32'h6, 32'h1, 1'b0, 1'b0, 32'h0, 1, 0, 1'b0, 32'h0);

    preload(32'h300, 32'h33);
    op("lr300_a", LR, 32'h300, 32'h0, 32'h33, 1'b0, 1'b0, 32'h0, 2, 1, 1'b0, 32'h0);
    snoop_pulse(32'h302);
    chk("snoop302_resv", {31'd0, c_resv}, 32'd0);
    op("sc300_snooped", SC, 32'h300, 32'h7, 32'h1, 1'b0, 1'b0, 32'h0, 1, 0, 1'b0, 32'h0);
    op("lr300_b", LR, 32'h300, 32'h0, 32'h33, 1'b0, 1'b0, 32'h0, 2, 1, 1'b0, 32'h0);
    snoop_pulse(32'h310);
    chk("snoop310_resv", {31'd0, c_resv}, 32'd1);
    op("sc300_ok", SC, 32'h300, 32'h8, 32'h0, 1'b0, 1'b1, 32'h8, 2, 1, 1'b0, 32'h0);
    op("lr300_c", LR, 32'h300, 32'h0, 32'h8, 1'b0, 1'b0, 32'h0, 2, 1, 1'b0, 32'h0);
    op("sc300_same_cycle_snoop", SC, 32'h300, 32'h9, 32'h1, 1'b0, 1'b0, 32'h0, 1, 0, 1'b1, 32'h304);

    sel = 1'b1;
    op("nosnoop_lr300", LR, 32'h300, 32'h0, 32'h8, 1'b0, 1'b0, 32'h0, 2, 1, 1'b0, 32'h0);
    snoop_pulse(32'h302);
    chk("nosnoop_resv", {31'd0, c_resv}, 32'd1);
    op("nosnoop_sc300", SC, 32'h300, 32'h9, 32'h0, 1'b0, 1'b1, 32'h9, 2, 1, 1'b0, 32'h0);
    sel = 1'b0;

    preload(32'h140, 32'h10);
    rd_stall = 4;
    op("stall_add", ADD, 32'h140, 32'h5, 32'h10, 1'b0, 1'b1, 32'h15, 7, 6, 1'b0, 32'h0);
    rd_stall = 0;

    preload(32'h200, 32'h77);
    op("lr_before_rst", LR, 32'h200, 32'h0, 32'h77, 1'b0, 1'b0, 32'h0, 2, 1, 1'b0, 32'h0);
    wr_stall = 10;
    issue(SWAP, 32'h160, 32'h1, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (c_req && c_we) found = 1'b1;
    end
    chk("rst_reach_wr", {31'd0, found}, 32'd1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    wr_stall = 0;
    @(negedge clk);
    chk("midwr_mem_req", {31'd0, c_req}, 32'd0);
    chk("midwr_ready", {31'd0, c_ready}, 32'd1);
    chk("midwr_resv", {31'd0, c_resv}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("midwr_no_resp", {31'd0, c_resp_valid}, 32'd0);
      @(negedge clk);
    end

    chk("scoreboard_empty", sbq.size(), 32'd0);
    chk("writes_empty", wq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
